// File: rtl/ipg_resp_inserter.sv
// Purpose: admit reply messages into a chunk FIFO and insert queued chunks into idle TX block slots.
// Latency: a chunk written in cycle N is popped in N+1 at the earliest and shown on ipg_tx_data in N+2.
// Backpressure: none upstream; whole messages are refused at admission when reserved space is short.
module ipg_resp_inserter #(
   parameter int DATA_WIDTH     = 64,
   parameter int DEPTH_LOG2     = 4,
   parameter int MAX_MSG_CHUNKS = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] ipg_reply_chunk,
   input  logic                  memq_write,
   input  logic                  tx_slot_avail,
   output logic [DATA_WIDTH-1:0] ipg_tx_data,
   output logic                  ipg_tx_valid,
   output logic [DEPTH_LOG2:0]   memq_count,
   output logic [15:0]           drop_msg_cnt,
   output logic [15:0]           orphan_cnt,
   output logic [15:0]           sent_msg_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] C_MAX   = (DEPTH_LOG2+1)'(MAX_MSG_CHUNKS);
   localparam logic [7:0] C_FIRST = 8'h0b;
   localparam logic [7:0] C_MID   = 8'h1b;
   localparam logic [7:0] C_LAST  = 8'h2b;

   typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_DROP} wstate_t;

   wstate_t               r_state;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_tx_valid;
   logic [15:0]           r_drop_cnt;
   logic [15:0]           r_orphan_cnt;
   logic [15:0]           r_sent_cnt;

   logic [7:0]          w_type;
   logic                w_first;
   logic                w_last;
   logic                w_midlast;
   logic                w_pop;
   logic                w_full;
   logic [DEPTH_LOG2:0] w_free;
   logic                w_admit;
   logic                w_overrun;
   logic                w_push;
   logic                w_inc_drop;
   logic                w_inc_orphan;

   assign w_type    = ipg_reply_chunk[7:0];
   assign w_first   = memq_write && (w_type == C_FIRST);
   assign w_last    = memq_write && (w_type == C_LAST);
   assign w_midlast = w_last || (memq_write && (w_type == C_MID));
   assign w_pop     = tx_slot_avail && (r_count != '0);
   assign w_full    = (r_count == C_DEPTH);
   // Admission looks at occupancy before this cycle's pop, so no credit for a departing chunk.
   assign w_free    = C_DEPTH - r_count;
   assign w_admit   = (w_free >= C_MAX);
   // A full FIFO can still take a chunk when the head leaves in the same cycle.
   assign w_overrun = w_full && !w_pop;

   assign w_push       = w_first ? w_admit
                                 : (w_midlast && (r_state == W_ACCEPT) && !w_overrun);
   assign w_inc_drop   = w_first && !w_admit;
   assign w_inc_orphan = w_midlast && ((r_state == W_IDLE) ||
                                       ((r_state == W_ACCEPT) && w_overrun));

   // Write-side message FSM; a FIRST in any state closes the current message and re-admits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= W_IDLE;
      end else if (w_first) begin
         r_state <= w_admit ? W_ACCEPT : W_DROP;
      end else if (w_midlast) begin
         case (r_state)
            W_ACCEPT: begin
               if (w_overrun)   r_state <= W_DROP;
               else if (w_last) r_state <= W_IDLE;
            end
            W_DROP: begin
               if (w_last) r_state <= W_IDLE;
            end
            default: r_state <= W_IDLE;
         endcase
      end
   end

   // Chunk storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= ipg_reply_chunk;
   end

   // Pointers wrap naturally at DEPTH_LOG2 bits; occupancy holds on simultaneous push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
            2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered TX slot: head chunk appears the cycle after the pop, zero otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_tx_valid <= w_pop;
         r_tx_data  <= w_pop ? r_mem[r_rd_ptr] : '0;
      end
   end

   // Statistics: drop/orphan saturate, sent wraps and steps alongside the LAST chunk's valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_cnt   <= '0;
         r_orphan_cnt <= '0;
         r_sent_cnt   <= '0;
      end else begin
         if (w_inc_drop && (r_drop_cnt != 16'hFFFF))     r_drop_cnt   <= r_drop_cnt + 16'd1;
         if (w_inc_orphan && (r_orphan_cnt != 16'hFFFF)) r_orphan_cnt <= r_orphan_cnt + 16'd1;
         if (w_pop && (r_mem[r_rd_ptr][7:0] == C_LAST))  r_sent_cnt   <= r_sent_cnt + 16'd1;
      end
   end

   assign ipg_tx_data  = r_tx_data;
   assign ipg_tx_valid = r_tx_valid;
   assign memq_count   = r_count;
   assign drop_msg_cnt = r_drop_cnt;
   assign orphan_cnt   = r_orphan_cnt;
   assign sent_msg_cnt = r_sent_cnt;

endmodule

// File: tb/tb_ipg_resp_inserter.sv
// Purpose: scoreboard bench for ipg_resp_inserter against a message-level reference model.
// Latency: model predicts slot-accurate tx_valid; expected chunks are queued at admission.
// Backpressure: tx_slot_avail is driven by directed patterns and random bias.
module tb_ipg_resp_inserter;

   localparam int DW    = 64;
   localparam int DEPTH = 16;
   localparam int MAXC  = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] ipg_reply_chunk;
   logic          memq_write;
   logic          tx_slot_avail;
   logic [DW-1:0] ipg_tx_data;
   logic          ipg_tx_valid;
   logic [4:0]    memq_count;
   logic [15:0]   drop_msg_cnt;
   logic [15:0]   orphan_cnt;
   logic [15:0]   sent_msg_cnt;

   ipg_resp_inserter #(.DATA_WIDTH(DW), .DEPTH_LOG2(4), .MAX_MSG_CHUNKS(MAXC)) dut (
      .clk             (clk),
      .reset           (reset),
      .ipg_reply_chunk (ipg_reply_chunk),
      .memq_write      (memq_write),
      .tx_slot_avail   (tx_slot_avail),
      .ipg_tx_data     (ipg_tx_data),
      .ipg_tx_valid    (ipg_tx_valid),
      .memq_count      (memq_count),
      .drop_msg_cnt    (drop_msg_cnt),
      .orphan_cnt      (orphan_cnt),
      .sent_msg_cnt    (sent_msg_cnt)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 0;

   // Reference model: what is stored, what is still owed on the wire, and message mode.
   logic [DW-1:0] m_fifo [$];
   logic [DW-1:0] exp_q  [$];
   int m_mode = 0;   // 0 between messages, 1 keeping a message, 2 discarding a message
   int m_drop = 0;
   int m_orph = 0;
   int m_sent = 0;
   bit m_vld  = 0;

   function automatic logic [DW-1:0] ck(input logic [7:0] t, input logic [31:0] p);
      return {24'h0, p, t};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void model_update(input logic [DW-1:0] d, input bit w, input bit a, input bit r);
      int cnt;
      bit pop;
      logic [DW-1:0] head;
      logic [7:0] t;
      if (r) begin
         m_fifo.delete();
         exp_q.delete();
         m_mode = 0; m_drop = 0; m_orph = 0; m_sent = 0; m_vld = 0;
         return;
      end
      cnt = m_fifo.size();
      pop = a && (cnt > 0);
      m_vld = pop;
      if (pop) begin
         head = m_fifo.pop_front();
         if (head[7:0] == 8'h2b) m_sent = (m_sent + 1) % 65536;
      end
      if (!w) return;
      t = d[7:0];
      if (t == 8'h0b) begin
         if (DEPTH - cnt >= MAXC) begin
            m_fifo.push_back(d); exp_q.push_back(d); m_mode = 1;
         end else begin
            if (m_drop < 65535) m_drop++;
            m_mode = 2;
         end
      end else if (t == 8'h1b || t == 8'h2b) begin
         if (m_mode == 0) begin
            if (m_orph < 65535) m_orph++;
         end else if (m_mode == 1) begin
            if (cnt == DEPTH && !pop) begin
               if (m_orph < 65535) m_orph++;
               m_mode = 2;
            end else begin
               m_fifo.push_back(d); exp_q.push_back(d);
               if (t == 8'h2b) m_mode = 0;
            end
         end else if (t == 8'h2b) begin
            m_mode = 0;
         end
      end
   endfunction

   task automatic step(input logic [DW-1:0] d, input bit w, input bit a, input bit r);
      ipg_reply_chunk = d;
      memq_write      = w;
      tx_slot_avail   = a;
      reset           = r;
      @(posedge clk);
      model_update(d, w, a, r);
      #1;
   endtask

   task automatic idle(input int n, input bit a);
      for (int i = 0; i < n; i++) step('0, 1'b0, a, 1'b0);
   endtask

   // Monitor: compares the slot and statistics every cycle, pops the scoreboard on valid.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (chk_en) begin
         chk("tx_valid", 64'(ipg_tx_valid), 64'(m_vld));
         if (ipg_tx_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_chunk", ipg_tx_data, '0);
            end else begin
               e = exp_q.pop_front();
               chk("tx_data", ipg_tx_data, e);
            end
         end else begin
            chk("tx_data_idle", ipg_tx_data, '0);
         end
         chk("memq_count",   64'(memq_count),   64'(m_fifo.size()));
         chk("drop_msg_cnt", 64'(drop_msg_cnt), 64'(m_drop));
         chk("orphan_cnt",   64'(orphan_cnt),   64'(m_orph));
         chk("sent_msg_cnt", 64'(sent_msg_cnt), 64'(m_sent));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] others [4];
      others[0] = 8'h00; others[1] = 8'h4b; others[2] = 8'hff; others[3] = 8'h0c;

      step('0, 1'b1, 1'b1, 1'b1);
      step('0, 1'b0, 1'b0, 1'b1);
      chk_en = 1;
      idle(2, 1'b1);

      // Basic message with slots always free: outputs back-to-back from two cycles after FIRST.
      step(ck(8'h0b, 32'h70), 1'b1, 1'b1, 1'b0);
      step(ck(8'h1b, 32'h71), 1'b1, 1'b1, 1'b0);
      step(ck(8'h2b, 32'h72), 1'b1, 1'b1, 1'b0);
      idle(5, 1'b1);
      chk("sent_after_first_msg", 64'(sent_msg_cnt), 64'd1);

      // Queue 11 entries, then a message that cannot be admitted (free 5 < 6).
      step(ck(8'h0b, 32'h100), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(ck(8'h1b, 32'h101 + i), 1'b1, 1'b0, 1'b0);
      step(ck(8'h2b, 32'h105), 1'b1, 1'b0, 1'b0);
      step(ck(8'h0b, 32'h200), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(ck(8'h1b, 32'h201 + i), 1'b1, 1'b0, 1'b0);
      step(ck(8'h2b, 32'h204), 1'b1, 1'b0, 1'b0);
      step(ck(8'h0b, 32'h300), 1'b1, 1'b0, 1'b0);
      step(ck(8'h1b, 32'h301), 1'b1, 1'b0, 1'b0);
      step(ck(8'h2b, 32'h302), 1'b1, 1'b0, 1'b0);
      idle(1, 1'b0);
      chk("refused_count_hold", 64'(memq_count), 64'd11);
      chk("refused_drop_cnt", 64'(drop_msg_cnt), 64'd1);
      idle(14, 1'b1);

      // Orphans outside any message.
      step(ck(8'h1b, 32'h400), 1'b1, 1'b1, 1'b0);
      step(ck(8'h2b, 32'h401), 1'b1, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("orphan_pair", 64'(orphan_cnt), 64'd2);

      // Fill to 16, then push with pop at full, then an overrunning LAST.
      step(ck(8'h0b, 32'h500), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) step(ck(8'h1b, 32'h501 + i), 1'b1, 1'b0, 1'b0);
      step(ck(8'h1b, 32'h510), 1'b1, 1'b1, 1'b0);
      step(ck(8'h2b, 32'h511), 1'b1, 1'b0, 1'b0);
      idle(20, 1'b1);

      // Slot availability toggling through a short message.
      step(ck(8'h0b, 32'h600), 1'b1, 1'b1, 1'b0);
      step(ck(8'h1b, 32'h601), 1'b1, 1'b0, 1'b0);
      step(ck(8'h2b, 32'h602), 1'b1, 1'b1, 1'b0);
      step('0, 1'b0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b0);
      idle(4, 1'b1);

      // Non-message chunk types are ignored entirely.
      for (int i = 0; i < 4; i++) step(ck(others[i], 32'h700), 1'b1, 1'b1, 1'b0);

      // Reset in the middle of a queued message; trailing LAST is an orphan.
      step(ck(8'h0b, 32'h800), 1'b1, 1'b0, 1'b0);
      step(ck(8'h1b, 32'h801), 1'b1, 1'b0, 1'b0);
      step(ck(8'h1b, 32'h802), 1'b1, 1'b1, 1'b1);
      chk("reset_count", 64'(memq_count), 64'd0);
      chk("reset_valid", 64'(ipg_tx_valid), 64'd0);
      step(ck(8'h2b, 32'h803), 1'b1, 1'b1, 1'b0);
      idle(1, 1'b1);
      chk("post_reset_orphan", 64'(orphan_cnt), 64'd1);

      // Randomized traffic with phases of scarce and plentiful slots.
      for (int i = 0; i < 3000; i++) begin
         int sel;
         int pav;
         logic [7:0] t;
         bit w;
         bit a;
         bit r;
         sel = int'($urandom_range(0, 99));
         if (sel < 20)      t = 8'h0b;
         else if (sel < 65) t = 8'h1b;
         else if (sel < 88) t = 8'h2b;
         else               t = others[$urandom_range(0, 3)];
         pav = ((i / 300) % 2 == 0) ? 30 : 85;
         w = ($urandom_range(0, 99) < 75);
         a = (int'($urandom_range(0, 99)) < pav);
         r = ($urandom_range(0, 999) == 0);
         step(ck(t, $urandom), w, a, r);
      end

      idle(40, 1'b1);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
